// File: rtl/regwrite_arbiter.sv
// Two-requester round-robin arbiter with bounded bursts that shares one register write path.
// The winning write is registered and presented to the decoder one cycle after its grant.
module regwrite_arbiter #(
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              a_sel,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic              b_sel,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              reg_select,
  output logic [DATA_W-1:0] reg_data,
  output logic              reg_we,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;  // 1 = B was granted last
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_a, grant_b;
  logic              reg_we_q, reg_select_q;
  logic [DATA_W-1:0] reg_data_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (a_valid && b_valid) begin
            grant_a = rr_last_q;
            grant_b = !rr_last_q;
          end else begin
            grant_a = a_valid;
            grant_b = b_valid;
          end
          if (grant_a) begin
            state_d = OWN_A;
            cnt_d   = CNT_ONE;
          end else if (grant_b) begin
            state_d = OWN_B;
            cnt_d   = CNT_ONE;
          end
        end
        OWN_A: begin
          if (a_valid && (cnt_q < CNT_MAX || !b_valid)) begin
            grant_a = 1'b1;
            cnt_d   = sat_inc(cnt_q);
          end else if (b_valid) begin
            grant_b = 1'b1;
            state_d = OWN_B;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        OWN_B: begin
          if (b_valid && (cnt_q < CNT_MAX || !a_valid)) begin
            grant_b = 1'b1;
            cnt_d   = sat_inc(cnt_q);
          end else if (a_valid) begin
            grant_a = 1'b1;
            state_d = OWN_A;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
      if (grant_a) rr_last_d = 1'b0;
      else if (grant_b) rr_last_d = 1'b1;
    end
  end

  // Stage boundary: arbitration state and registered decoder write
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_last_q    <= 1'b1;
      cnt_q        <= '0;
      reg_we_q     <= 1'b0;
      reg_select_q <= 1'b0;
      reg_data_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      reg_we_q  <= grant_a | grant_b;
      if (grant_a) begin
        reg_select_q <= a_sel;
        reg_data_q   <= a_data;
      end else if (grant_b) begin
        reg_select_q <= b_sel;
        reg_data_q   <= b_data;
      end
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign reg_we     = reg_we_q;
  assign reg_select = reg_select_q;
  assign reg_data   = reg_data_q;
  assign owner      = state_q;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed bench for regwrite_arbiter: a cycle-level grant model checked every cycle,
// plus hand-computed expectations for the reset, single, contention and handover scenarios.
module tb_regwrite_arbiter;
  localparam int DW   = 16;
  localparam int BMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_sel, a_ready;
  logic [DW-1:0] a_data;
  logic          b_valid, b_sel, b_ready;
  logic [DW-1:0] b_data;
  logic          reg_select, reg_we;
  logic [DW-1:0] reg_data;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  regwrite_arbiter #(.DATA_W(DW), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
    .reg_select(reg_select), .reg_data(reg_data), .reg_we(reg_we), .owner(owner)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: who was granted last cycle, how long the current run is, who won most recently.
  int            m_prev = 0;    // 0 none, 1 A, 2 B (previous cycle's grant)
  int            m_run  = 0;    // consecutive grants to m_prev, capped at BMAX
  logic          m_last = 1'b1; // 1 = B granted most recently
  logic          m_we = 1'b0, m_sel = 1'b0;
  logic [DW-1:0] m_data = '0;
  bit            m_ok = 1'b0;
  logic          g_a = 1'b0, g_b = 1'b0;
  logic [DW-1:0] wlog[$];

  always @(negedge clk) begin
    logic ea, eb;
    ea = 1'b0;
    eb = 1'b0;
    if (m_ok) begin
      if (!rst) begin
        if (a_valid && b_valid) begin
          if (m_prev != 0 && m_run < BMAX) begin
            ea = (m_prev == 1);
            eb = (m_prev == 2);
          end else begin
            ea = m_last;
            eb = !m_last;
          end
        end else begin
          ea = a_valid;
          eb = b_valid;
        end
      end
      check("model_a_ready", a_ready, ea);
      check("model_b_ready", b_ready, eb);
      check("model_reg_we", reg_we, m_we);
      check("model_reg_select", reg_select, m_sel);
      check("model_reg_data", reg_data, m_data);
      check("model_owner", owner, m_prev[1:0]);
      if (reg_we) wlog.push_back(reg_data);
    end
    g_a <= ea;
    g_b <= eb;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1; m_prev <= 0; m_run <= 0; m_last <= 1'b1;
      m_we <= 1'b0; m_sel <= 1'b0; m_data <= '0;
    end else if (m_ok) begin
      if (g_a) begin
        m_run  <= (m_prev == 1) ? ((m_run < BMAX) ? m_run + 1 : BMAX) : 1;
        m_prev <= 1; m_last <= 1'b0;
        m_we <= 1'b1; m_sel <= a_sel; m_data <= a_data;
      end else if (g_b) begin
        m_run  <= (m_prev == 2) ? ((m_run < BMAX) ? m_run + 1 : BMAX) : 1;
        m_prev <= 2; m_last <= 1'b1;
        m_we <= 1'b1; m_sel <= b_sel; m_data <= b_data;
      end else begin
        m_prev <= 0; m_run <= 0; m_we <= 1'b0;
      end
    end
  end

  // Requester sources: each holds valid/data until the beat is accepted.
  int            a_left = 0, b_left = 0;
  logic [DW-1:0] a_nx = '0, b_nx = '0;
  bit            acc_a, acc_b;

  task automatic tick();
    a_valid = (a_left > 0);
    a_data  = a_nx;
    b_valid = (b_left > 0);
    b_data  = b_nx;
    @(negedge clk);
    acc_a = a_valid && a_ready;
    acc_b = b_valid && b_ready;
    @(posedge clk);
    #1;
    if (acc_a) begin a_left--; a_nx++; end
    if (acc_b) begin b_left--; b_nx++; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [DW-1:0] exp_c [16] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                                16'h2000, 16'h2001, 16'h2002, 16'h2003,
                                16'h1004, 16'h1005, 16'h1006, 16'h1007,
                                16'h2004, 16'h2005, 16'h2006, 16'h2007};

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_sel = 1'b0; a_data = '0;
    b_valid = 1'b0; b_sel = 1'b0; b_data = '0;

    // Reset held two cycles with both requesters valid
    a_left = 1; b_left = 1;
    tick();
    check("rst1_a_ready", acc_a, 1'b0);
    check("rst1_b_ready", acc_b, 1'b0);
    tick();
    check("rst2_a_ready", acc_a, 1'b0);
    check("rst2_b_ready", acc_b, 1'b0);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_reg_select", reg_select, 1'b0);
    check("rst_reg_data", reg_data, 16'h0000);
    check("rst_owner", owner, 2'b00);
    a_left = 0; b_left = 0;
    rst = 1'b0;

    // Single write from A
    a_sel = 1'b1; a_nx = 16'h00A5; a_left = 1;
    tick();
    check("single_a_ready", acc_a, 1'b1);
    check("single_reg_we", reg_we, 1'b1);
    check("single_reg_select", reg_select, 1'b1);
    check("single_reg_data", reg_data, 16'h00A5);
    check("single_owner", owner, 2'b01);
    tick();
    check("single_we_drop", reg_we, 1'b0);
    check("single_idle_owner", owner, 2'b00);

    // Contention with bounded bursts
    do_reset();
    wlog.delete();
    a_sel = 1'b0; b_sel = 1'b1;
    a_nx = 16'h1000; b_nx = 16'h2000; a_left = 8; b_left = 8;
    repeat (17) tick();
    check("cont_writes", wlog.size(), 16);
    for (int k = 0; k < 16; k++)
      if (k < wlog.size()) check($sformatf("cont_write%0d", k), wlog[k], exp_c[k]);

    // Saturated owner hands over on the first cycle B is seen
    a_nx = 16'h5000; b_nx = 16'h6000; b_sel = 1'b0; a_left = 10;
    for (int c = 1; c <= 11; c++) begin
      if (c == 7) b_left = 1;
      tick();
      check($sformatf("sat_c%0d_a", c), acc_a, (c == 7) ? 1'b0 : 1'b1);
      check($sformatf("sat_c%0d_b", c), acc_b, (c == 7) ? 1'b1 : 1'b0);
    end
    check("sat_a_done", a_left, 0);
    tick();

    // Both sides target reg0 right after reset
    do_reset();
    a_sel = 1'b0; b_sel = 1'b0; a_nx = 16'h3A3A; b_nx = 16'h4B4B; a_left = 1; b_left = 1;
    tick();
    check("same_first_a", acc_a, 1'b1);
    check("same_first_b", acc_b, 1'b0);
    check("same_first_data", reg_data, 16'h3A3A);
    tick();
    check("same_second_b", acc_b, 1'b1);
    check("same_second_data", reg_data, 16'h4B4B);
    check("same_second_select", reg_select, 1'b0);
    tick();
    check("same_final_we", reg_we, 1'b0);
    check("same_final_data", reg_data, 16'h4B4B);

    // Reset on A's third beat
    a_sel = 1'b1; a_nx = 16'h7000; a_left = 5;
    tick();
    tick();
    check("mid_beat2_we", reg_we, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_no_accept", acc_a, 1'b0);
    check("mid_rst_we_cleared", reg_we, 1'b0);
    rst = 1'b0;
    b_nx = 16'h8000; b_left = 1;
    tick();
    check("mid_after_a_wins", acc_a, 1'b1);
    check("mid_after_b_waits", acc_b, 1'b0);
    check("mid_after_data", reg_data, 16'h7002);
    repeat (5) tick();
    check("mid_drained", a_left + b_left, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
